priority_encoder: RTL

Registered 8-to-3 priority encoder with active-low request inputs and cascade enables, the encoding counterpart of the lab's 3-to-8 decoder. The encoded outputs fed to the decoder's A/B/C, with the decoder enabled, drive the decoder output for the highest active request low. Inputs are synchronised and glitch-filtered. Each new active code is also delivered as a one-entry event with a valid/ready handshake, so a downstream consumer such as a display or counter block receives each press exactly once.

---
 rtl/priority_encoder_if.sv | 22 ++
 rtl/priority_encoder.sv | 105 ++++++++++
 2 files changed

// File: rtl/priority_encoder_if.sv
// priority_encoder_if: request/enable inputs, encoded outputs and event handshake of the priority encoder.
interface priority_encoder_if;
    logic [7:0] i_n;
    logic       ei_n;
    logic       a;
    logic       b;
    logic       c;
    logic       gs_n;
    logic       eo_n;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic       overrun;
    modport master (
        output i_n, ei_n, evt_ready,
        input  a, b, c, gs_n, eo_n, evt_valid, evt_code, overrun
    );
    modport slave (
        input  i_n, ei_n, evt_ready,
        output a, b, c, gs_n, eo_n, evt_valid, evt_code, overrun
    );
endinterface

// File: rtl/priority_encoder.sv
// priority_encoder: synchronised, glitch-filtered 8-to-3 priority encoder with a one-entry press event queue.
module priority_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    priority_encoder_if.slave pe
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    typedef enum logic {IDLE, PEND} state_e;
    logic [8:0]    sync1_q, sync2_q, samp_q, filt_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          match;
    logic [2:0]    idx, code_d, code_q;
    logic          gs_d, gs_q, eo_d, eo_q;
    logic          evt_cond;
    state_e        state_q, state_d;
    logic [2:0]    evt_code_d, evt_code_q;
    logic          dirty_d, dirty_q, overrun_d, overrun_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {pe.ei_n, pe.i_n};
            sync2_q <= sync1_q;
        end
    end
    // cnt_q counts how many consecutive edges stage 2 matched the held sample
    assign match = sync2_q == samp_q;
    assign cnt_d = !match ? '0 : (cnt_q == CW'(STABLE_CYCLES - 1)) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= '1;
            cnt_q  <= '0;
            filt_q <= '1;
        end else begin
            samp_q <= sync2_q;
            cnt_q  <= cnt_d;
            if (cnt_d == CW'(STABLE_CYCLES - 1))
                filt_q <= sync2_q;
        end
    end
    always_comb begin
        idx = '0;
        for (int k = 0; k < 8; k++)
            if (!filt_q[k]) idx = 3'(k);
        code_d = filt_q[8] ? 3'd0 : idx;
        gs_d   = filt_q[8] | (&filt_q[7:0]);
        eo_d   = filt_q[8] | ~(&filt_q[7:0]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            gs_q   <= 1'b1;
            eo_q   <= 1'b1;
        end else begin
            code_q <= code_d;
            gs_q   <= gs_d;
            eo_q   <= eo_d;
        end
    end
    assign evt_cond = !gs_d && (gs_q || code_d != code_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            evt_code_q <= '0;
            dirty_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            evt_code_q <= evt_code_d;
            dirty_q    <= dirty_d;
            overrun_q  <= overrun_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (evt_cond || (dirty_q && !gs_q)) ? PEND : IDLE;
        else
            state_d = pe.evt_ready ? IDLE : PEND;
    end
    // a press missed while busy is replayed from the live code once the consumer frees up
    always_comb begin
        evt_code_d = evt_code_q;
        dirty_d    = dirty_q;
        overrun_d  = 1'b0;
        if (state_q == IDLE) begin
            evt_code_d = evt_cond ? code_d : (dirty_q && !gs_q) ? code_q : evt_code_q;
            dirty_d    = 1'b0;
        end else begin
            dirty_d    = dirty_q | evt_cond;
            overrun_d  = evt_cond & ~pe.evt_ready;
        end
    end
    assign pe.a         = code_q[0];
    assign pe.b         = code_q[1];
    assign pe.c         = code_q[2];
    assign pe.gs_n      = gs_q;
    assign pe.eo_n      = eo_q;
    assign pe.evt_valid = state_q == PEND;
    assign pe.evt_code  = evt_code_q;
    assign pe.overrun   = overrun_q;
endmodule
